spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- SPI target (slave) engine: the receiving end of the link whose SCK the master-side clock generator produces.
- Oversamples an external SCK/CSN/MOSI with the system clock and detects SCK edges.
- Deserialises MOSI into words and serialises MISO from a TX holding register.
- Supports all four CPOL/CPHA modes plus MSB/LSB-first ordering. Sits between the SPI pads and a register or FIFO front end.

Parameters:
DATA_WIDTH, 8, bits per SPI word (2..32)
SYNC_STAGES, 2, synchroniser flops on sck_i, csn_i, mosi_i (>=2)
TX_IDLE, {DATA_WIDTH{1'b1}}, word shifted out on TX underrun

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
cpol_i  in  1  SCK idle level; static while csn_i high
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first_i  in  1  1: LSB first on both MOSI and MISO
sck_i  in  1  SPI clock from master (asynchronous)
csn_i  in  1  chip select, active-low (asynchronous)
mosi_i  in  1  master-out data (asynchronous)
miso_o  out  1  slave-out data
miso_oe_o  out  1  MISO output enable
tx_data_i  in  DATA_WIDTH  word to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  TX holding register empty
rx_data_o  out  DATA_WIDTH  last received word
rx_valid_o  out  1  rx_data_o holds an unread word
rx_ready_i  in  1  consumer accepts rx_data_o
busy_o  out  1  frame active (synchronised CSN low)
tx_underrun_o  out  1  one-cycle pulse: TX_IDLE loaded
rx_overrun_o  out  1  one-cycle pulse: received word dropped

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, both pulse outputs 0.
- Internal state cleared on reset: shift registers and bit counters.
- Synchronisers: sck_i, csn_i and mosi_i each pass through SYNC_STAGES flops. A further flop on sck gives edge detection.
- SCK requirement: high and low phases of >= SYNC_STAGES+2 clk_i cycles each.
- Edge classification: leading edge = rising if cpol_i=0, falling if cpol_i=1. Sample edge = leading if cpha_i=0, trailing if cpha_i=1. Shift edge = the other edge.
- Edges are ignored while synchronised CSN is high.
- States:
  - IDLE: CSN high. Transitions to ACTIVE on synchronised CSN falling.
  - ACTIVE: sets busy_o=1 and miso_oe_o=1. Returns to IDLE on synchronised CSN rising.
- Frame start:
  - cpha_i=0: TX shift register loaded on entry to ACTIVE; first bit on miso_o the cycle after busy_o rises.
  - cpha_i=1: load occurs at the first shift edge.
- Shift edge, TX word position 0 (word boundary): load a new word. This is the first shift edge for cpha=1, or the DATA_WIDTH-th shift edge for cpha=0. Otherwise shift one bit.
  - miso_o updates 1 clk after the detected edge.
  - Bit order: MSB first, or LSB first when lsb_first_i=1.
- TX load:
  - If the holding register is full: move it to the shift register and assert tx_ready_o=1 next cycle.
  - If empty: load TX_IDLE and pulse tx_underrun_o.
- TX handshake: tx_valid_i & tx_ready_o writes the holding register; tx_ready_o=0 next cycle. A write and a load in the same cycle is allowed: the written word goes to the holding register.
- Sample edge: shift the synchronised MOSI into the RX shift register and increment the bit counter. When the counter reaches DATA_WIDTH, the word completes and the counter wraps to 0.
- RX completion:
  - If rx_valid_o=0, or rx_ready_i=1 in the same cycle: rx_data_o <= word and rx_valid_o=1 next cycle.
  - Otherwise the new word is dropped, rx_data_o is kept, and rx_overrun_o pulses.
  - rx_valid_o clears on rx_valid_o & rx_ready_i when no completion occurs.
- CSN rise mid-word: partial RX word discarded (no rx_valid_o), counters cleared, current TX shift word discarded, holding register untouched.
- On CSN rise: miso_oe_o=0, miso_o=0, busy_o=0, all one cycle after synchronised CSN rises.
- cpol_i, cpha_i and lsb_first_i are sampled only while IDLE.
- rst_i mid-frame: returns to reset values immediately. A frame in progress is ignored until CSN goes high then low.

Test Plan:
- Mode 0, MSB first, tx 0x3C preloaded, master sends 0xA5 -> rx_data_o=0xA5 and rx_valid_o=1; master samples MISO bits 0,0,1,1,1,1,0,0; tx_ready_o=1 after frame start.
- Mode 3, two back-to-back words 0x12, 0x34 in one CSN frame; tx 0xC1 then 0xD2 written when tx_ready_o rises -> rx 0x12 then 0x34; master reads 0xC1, 0xD2; no pulse outputs.
- Mode 1, no TX write -> master reads 0xFF; tx_underrun_o pulses exactly once per word.
- Two words received with rx_ready_i=0 -> rx_data_o stays first word; rx_overrun_o one pulse; rx_valid_o stays 1.
- CSN released after 5 of 8 bits, then full frame 0x5A -> no rx_valid_o for the partial word; next rx_data_o=0x5A.
- Mode 2, lsb_first_i=1, master sends 0x01 LSB-first, tx 0x80 -> rx_data_o=0x01; MISO bits 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples SCK/CSN/MOSI with clk_i, deserialises MOSI into
// rx_data_o and serialises a TX holding register onto MISO in any CPOL/CPHA mode.
`timescale 1ns/1ps
module spi_slave_core #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_first_i,
    input  logic                  sck_i,
    input  logic                  csn_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  tx_underrun_o,
    output logic                  rx_overrun_o
);

    localparam int             CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sr, csn_sr, mosi_sr;
    logic                    sck_d, csn_d;
    logic                    cpol_q, cpha_q, lsb_q;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_full;
    logic [DATA_WIDTH-1:0]   tx_shift, tx_shift_d;
    logic [CW-1:0]           tx_cnt, tx_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_shift, rx_word;
    logic [CW-1:0]           rx_cnt;
    logic                    miso_q;
    logic                    tx_load, tx_write, rx_done;

    wire sck_s  = sck_sr[SYNC_STAGES-1];
    wire csn_s  = csn_sr[SYNC_STAGES-1];
    wire mosi_s = mosi_sr[SYNC_STAGES-1];

    wire csn_fall = csn_d & ~csn_s;
    wire csn_rise = ~csn_d & csn_s;
    wire sck_rise = sck_s & ~sck_d;
    wire sck_fall = ~sck_s & sck_d;
    wire lead     = cpol_q ? sck_fall : sck_rise;
    wire trail    = cpol_q ? sck_rise : sck_fall;
    wire in_frame = (state_q == ACTIVE) & ~csn_s;
    wire sample_edge = in_frame & (cpha_q ? trail : lead);
    wire shift_edge  = in_frame & (cpha_q ? lead : trail);
    wire start    = (state_q == IDLE) & csn_fall;
    wire stop     = (state_q == ACTIVE) & csn_rise;

    // The CSN chain resets low so a frame already running at reset release
    // produces no falling edge: the master must deselect and reselect first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sr  <= '0;
            csn_sr  <= '0;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            csn_d   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck_i};
            csn_sr  <= {csn_sr[SYNC_STAGES-2:0], csn_i};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi_i};
            sck_d   <= sck_s;
            csn_d   <= csn_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (csn_fall) state_d = ACTIVE;
            ACTIVE:  if (csn_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_shift_d = tx_shift;
        tx_cnt_d   = tx_cnt;
        tx_load    = 1'b0;
        if (stop) begin
            tx_shift_d = '0;
            tx_cnt_d   = '0;
        end else if (start) begin
            // cpha=0 presents bit 0 before the first edge, so load on entry.
            tx_load  = ~cpha_i;
            tx_cnt_d = cpha_i ? '0 : CW'(1);
        end else if (shift_edge) begin
            if (tx_cnt == '0) begin
                tx_load  = 1'b1;
                tx_cnt_d = CW'(1);
            end else begin
                tx_shift_d = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
                tx_cnt_d   = (tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
            end
        end
        if (tx_load) tx_shift_d = hold_full ? hold_data : TX_IDLE;
    end

    assign tx_write = tx_valid_i & ~hold_full;
    assign rx_word  = lsb_q ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                            : {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign rx_done  = sample_edge & (rx_cnt == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            lsb_q         <= 1'b0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_shift      <= '0;
            tx_cnt        <= '0;
            rx_shift      <= '0;
            rx_cnt        <= '0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            miso_q        <= 1'b0;
            tx_underrun_o <= 1'b0;
            rx_overrun_o  <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                cpol_q <= cpol_i;
                cpha_q <= cpha_i;
                lsb_q  <= lsb_first_i;
            end

            // A write can only happen while empty, so it never collides with a
            // load draining a full register.
            if (tx_write) begin
                hold_data <= tx_data_i;
                hold_full <= 1'b1;
            end else if (tx_load) begin
                hold_full <= 1'b0;
            end
            tx_underrun_o <= tx_load & ~hold_full;
            tx_shift      <= tx_shift_d;
            tx_cnt        <= tx_cnt_d;

            // IDLE compare keeps MISO low for the entry cycle, putting bit 0
            // out one cycle after busy_o rises.
            if ((state_q == ACTIVE) && !stop)
                miso_q <= lsb_q ? tx_shift_d[0] : tx_shift_d[DATA_WIDTH-1];
            else
                miso_q <= 1'b0;

            if (stop || start) begin
                rx_shift <= '0;
                rx_cnt   <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_word;
                rx_cnt   <= rx_done ? '0 : rx_cnt + 1'b1;
            end

            rx_overrun_o <= 1'b0;
            if (rx_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= rx_word;
                    rx_valid_o <= 1'b1;
                end else begin
                    rx_overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign miso_o     = miso_q;
    assign busy_o     = (state_q == ACTIVE);
    assign miso_oe_o  = (state_q == ACTIVE);
    assign tx_ready_o = ~hold_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives each mode
// and compares MISO words, RX words and status pulses with hand-computed values.
`timescale 1ns/1ps
module tb_spi_slave_core;

    localparam int HP = 100;  // SCK half period: 10 system clocks

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic       sck = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o;
    logic       tx_underrun_o, rx_overrun_o;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_ready = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int underrun_cnt = 0;
    int overrun_cnt  = 0;
    logic [7:0] rx_log[$];

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb),
        .sck_i(sck), .csn_i(csn), .mosi_i(mosi),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .busy_o(busy_o), .tx_underrun_o(tx_underrun_o), .rx_overrun_o(rx_overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_underrun_o) underrun_cnt++;
        if (rx_overrun_o)  overrun_cnt++;
        if (rx_valid_o && rx_ready) rx_log.push_back(rx_data_o);
    end

    task automatic set_mode(input logic pol, input logic pha, input logic lf);
        @(negedge clk);
        cpol = pol; cpha = pha; lsb = lf; sck = pol;
        repeat (6) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        while (!tx_ready_o && n < 400) begin @(negedge clk); n++; end
        compared++;
        if (!tx_ready_o) begin
            mismatched++;
            $display("FAIL tx_write_timeout: tx_ready_o=%b after %0d cycles, required 1", tx_ready_o, n);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic begin_frame();
        @(negedge clk);
        csn = 1'b0;
        #(HP);
    endtask

    task automatic end_frame();
        #(HP);
        csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb ? i : 7 - i;
            if (!cpha) mosi = mo[b];
            #(HP);
            if (!cpha) mi[b] = miso_o;
            sck = ~sck;
            if (cpha) mosi = mo[b];
            #(HP);
            if (cpha) mi[b] = miso_o;
            sck = ~sck;
        end
    endtask

    task automatic drain_rx();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        compared++;
        if ({miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o, tx_underrun_o, rx_overrun_o} !== 7'b0010000) begin
            mismatched++;
            $display("FAIL reset_flags: {miso,oe,txr,rxv,busy,und,ovr}=%b required 0010000",
                     {miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o, tx_underrun_o, rx_overrun_o});
        end
        compared++;
        if (rx_data_o !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data_o);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] mi;
        int und0;
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(8'h3C);
        @(negedge clk);
        compared++;
        if (tx_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL m0_ready_after_write: got %b required 0", tx_ready_o);
        end
        und0 = underrun_cnt;
        begin_frame();
        compared++;
        if ({busy_o, miso_oe_o, tx_ready_o} !== 3'b111) begin
            mismatched++;
            $display("FAIL m0_frame_start: {busy,oe,txr}=%b required 111", {busy_o, miso_oe_o, tx_ready_o});
        end
        xfer(8'hA5, 8, mi);
        end_frame();
        compared++;
        if (mi !== 8'h3C) begin
            mismatched++;
            $display("FAIL m0_miso_word: got %h required 3c", mi);
        end
        compared++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'hA5}) begin
            mismatched++;
            $display("FAIL m0_rx: valid=%b data=%h required 1/a5", rx_valid_o, rx_data_o);
        end
        compared++;
        if ({busy_o, miso_oe_o, miso_o} !== 3'b000) begin
            mismatched++;
            $display("FAIL m0_frame_end: {busy,oe,miso}=%b required 000", {busy_o, miso_oe_o, miso_o});
        end
        // The eighth trailing edge reloads from an empty holding register.
        compared++;
        if (underrun_cnt - und0 !== 1) begin
            mismatched++;
            $display("FAIL m0_underrun_count: got %0d required 1", underrun_cnt - und0);
        end
        drain_rx();
        compared++;
        if (rx_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL m0_rx_drain: rx_valid=%b required 0", rx_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi1, mi2;
        int und0, ovr0;
        set_mode(1'b1, 1'b1, 1'b0);
        rx_ready = 1'b1;
        tx_write(8'hC1);
        @(negedge clk);
        rx_log.delete();
        und0 = underrun_cnt; ovr0 = overrun_cnt;
        begin_frame();
        fork
            begin
                xfer(8'h12, 8, mi1);
                xfer(8'h34, 8, mi2);
            end
            begin
                int n = 0;
                while (!tx_ready_o && n < 400) begin @(negedge clk); n++; end
                tx_write(8'hD2);
            end
        join
        end_frame();
        rx_ready = 1'b0;
        compared++;
        if ({mi1, mi2} !== 16'hC1D2) begin
            mismatched++;
            $display("FAIL b2b_miso_words: got %h %h required c1 d2", mi1, mi2);
        end
        compared++;
        if (rx_log.size() !== 2) begin
            mismatched++;
            $display("FAIL b2b_rx_count: got %0d required 2", rx_log.size());
        end else begin
            compared++;
            if ({rx_log[0], rx_log[1]} !== 16'h1234) begin
                mismatched++;
                $display("FAIL b2b_rx_words: got %h %h required 12 34", rx_log[0], rx_log[1]);
            end
        end
        compared++;
        if ((underrun_cnt - und0) + (overrun_cnt - ovr0) !== 0) begin
            mismatched++;
            $display("FAIL b2b_pulses: underruns=%0d overruns=%0d required 0/0",
                     underrun_cnt - und0, overrun_cnt - ovr0);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mi1, mi2;
        int und0;
        set_mode(1'b0, 1'b1, 1'b0);
        und0 = underrun_cnt;
        begin_frame();
        xfer(8'h00, 8, mi1);
        compared++;
        if (underrun_cnt - und0 !== 1) begin
            mismatched++;
            $display("FAIL und_first_word_pulses: got %0d required 1", underrun_cnt - und0);
        end
        xfer(8'h00, 8, mi2);
        end_frame();
        compared++;
        if ({mi1, mi2} !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL und_miso_words: got %h %h required ff ff", mi1, mi2);
        end
        compared++;
        if (underrun_cnt - und0 !== 2) begin
            mismatched++;
            $display("FAIL und_pulse_count: got %0d required 2", underrun_cnt - und0);
        end
        drain_rx();
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int ovr0;
        set_mode(1'b0, 1'b1, 1'b0);
        ovr0 = overrun_cnt;
        begin_frame();
        xfer(8'h81, 8, mi);
        xfer(8'h7E, 8, mi);
        end_frame();
        compared++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h81}) begin
            mismatched++;
            $display("FAIL ovr_rx_kept: valid=%b data=%h required 1/81", rx_valid_o, rx_data_o);
        end
        compared++;
        if (overrun_cnt - ovr0 !== 1) begin
            mismatched++;
            $display("FAIL ovr_pulse_count: got %0d required 1", overrun_cnt - ovr0);
        end
        drain_rx();
    endtask

    task automatic test_partial();
        logic [7:0] mi;
        set_mode(1'b0, 1'b1, 1'b0);
        begin_frame();
        xfer(8'hFF, 5, mi);
        end_frame();
        compared++;
        if (rx_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL partial_no_valid: rx_valid=%b required 0", rx_valid_o);
        end
        begin_frame();
        xfer(8'h5A, 8, mi);
        end_frame();
        compared++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h5A}) begin
            mismatched++;
            $display("FAIL partial_next_word: valid=%b data=%h required 1/5a", rx_valid_o, rx_data_o);
        end
        drain_rx();
    endtask

    task automatic test_mode2_lsb();
        logic [7:0] mi;
        set_mode(1'b1, 1'b0, 1'b1);
        tx_write(8'h80);
        begin_frame();
        xfer(8'h01, 8, mi);
        end_frame();
        compared++;
        if (mi !== 8'h80) begin
            mismatched++;
            $display("FAIL m2_miso_word: got %h required 80", mi);
        end
        compared++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h01}) begin
            mismatched++;
            $display("FAIL m2_rx: valid=%b data=%h required 1/01", rx_valid_o, rx_data_o);
        end
        drain_rx();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        set_mode(1'b0, 1'b0, 1'b0);
        begin_frame();
        rst = 1'b1;
        #3;
        compared++;
        if ({busy_o, miso_oe_o, tx_ready_o} !== 3'b001) begin
            mismatched++;
            $display("FAIL midrst_async: {busy,oe,txr}=%b required 001", {busy_o, miso_oe_o, tx_ready_o});
        end
        @(negedge clk);
        rst = 1'b0;
        xfer(8'hFF, 8, mi);
        #(HP);
        compared++;
        if ({busy_o, miso_oe_o, rx_valid_o} !== 3'b000) begin
            mismatched++;
            $display("FAIL midrst_frame_ignored: {busy,oe,rxv}=%b required 000", {busy_o, miso_oe_o, rx_valid_o});
        end
        csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_partial();
        test_mode2_lsb();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
